hazard_fwd_ctrl: RTL

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_if.sv | 36 +++
 rtl/hazard_fwd_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request and hazard/forwarding response signals between the decode
// stage and the hazard unit.
interface hazard_fwd_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;

    logic             ex_reg_dst;
    logic [4:0]       ex_dest;
    logic [4:0]       mem_dest;
    logic [4:0]       wb_dest;
    logic             wb_reg_write;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read, flush,
        input  ex_reg_dst, ex_dest, mem_dest, wb_dest, wb_reg_write, fwd_a, fwd_b, stall,
               stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read, flush,
        output ex_reg_dst, ex_dest, mem_dest, wb_dest, wb_reg_write, fwd_a, fwd_b, stall,
               stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard unit: tracks ID/EX, EX/MEM and MEM/WB control fields, selects ALU
// operand forwarding, and stalls one cycle on load-use with a saturating stall counter.
module hazard_fwd_ctrl #(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_ctrl_if.slave bus
);
    logic             idex_valid_q;
    logic [4:0]       idex_rs_q;
    logic [4:0]       idex_rt_q;
    logic [4:0]       idex_rd_q;
    logic             idex_reg_dst_q;
    logic             idex_reg_write_q;
    logic             idex_mem_read_q;

    logic [4:0]       exmem_dest_q;
    logic             exmem_reg_write_q;
    logic             exmem_mem_read_q;

    logic [4:0]       memwb_dest_q;
    logic             memwb_reg_write_q;

    logic [CNT_W-1:0] cnt_q;

    logic [4:0]       ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    always_comb begin
        ex_dest      = idex_reg_dst_q ? idex_rd_q : idex_rt_q;
        ex_reg_write = idex_valid_q & idex_reg_write_q;
        ex_mem_read  = idex_valid_q & idex_mem_read_q;
        stall        = ex_reg_write & ex_mem_read & (ex_dest != 5'd0) & bus.id_valid &
                       ((ex_dest == bus.id_rs) | (ex_dest == bus.id_rt)) & ~bus.flush;
        bubble       = stall | bus.flush;
    end

    // EX/MEM wins over MEM/WB; register 0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        if (exmem_reg_write_q && (exmem_dest_q != 5'd0) && (exmem_dest_q == idex_rs_q)) begin
            fwd_a = 2'b10;
        end else if (memwb_reg_write_q && (memwb_dest_q != 5'd0) &&
                     (memwb_dest_q == idex_rs_q)) begin
            fwd_a = 2'b01;
        end

        fwd_b = 2'b00;
        if (exmem_reg_write_q && (exmem_dest_q != 5'd0) && (exmem_dest_q == idex_rt_q)) begin
            fwd_b = 2'b10;
        end else if (memwb_reg_write_q && (memwb_dest_q != 5'd0) &&
                     (memwb_dest_q == idex_rt_q)) begin
            fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q      <= 1'b0;
            idex_rs_q         <= 5'd0;
            idex_rt_q         <= 5'd0;
            idex_rd_q         <= 5'd0;
            idex_reg_dst_q    <= 1'b0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            exmem_dest_q      <= 5'd0;
            exmem_reg_write_q <= 1'b0;
            exmem_mem_read_q  <= 1'b0;
            memwb_dest_q      <= 5'd0;
            memwb_reg_write_q <= 1'b0;
            cnt_q             <= '0;
        end else begin
            if (bubble) begin
                idex_valid_q     <= 1'b0;
                idex_rs_q        <= 5'd0;
                idex_rt_q        <= 5'd0;
                idex_rd_q        <= 5'd0;
                idex_reg_dst_q   <= 1'b0;
                idex_reg_write_q <= 1'b0;
                idex_mem_read_q  <= 1'b0;
            end else begin
                idex_valid_q     <= bus.id_valid;
                idex_rs_q        <= bus.id_rs;
                idex_rt_q        <= bus.id_rt;
                idex_rd_q        <= bus.id_rd;
                idex_reg_dst_q   <= bus.id_reg_dst;
                idex_reg_write_q <= bus.id_reg_write;
                idex_mem_read_q  <= bus.id_mem_read;
            end

            exmem_dest_q      <= ex_dest;
            exmem_reg_write_q <= ex_reg_write;
            exmem_mem_read_q  <= ex_mem_read;

            memwb_dest_q      <= exmem_dest_q;
            memwb_reg_write_q <= exmem_reg_write_q;

            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // A load in MEM has no data yet; the load-use stall must keep any valid consumer away.
    a_no_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
        !(exmem_mem_read_q && idex_valid_q && ((fwd_a == 2'b10) || (fwd_b == 2'b10))));

    assign bus.ex_reg_dst   = idex_reg_dst_q;
    assign bus.ex_dest      = ex_dest;
    assign bus.mem_dest     = exmem_dest_q;
    assign bus.wb_dest      = memwb_dest_q;
    assign bus.wb_reg_write = memwb_reg_write_q;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.stall        = stall;
    assign bus.stall_cnt    = cnt_q;
endmodule
